// File: rtl/score_tracker.sv
// Scores one chart note per window: the normalised played note must match the
// target for HOLD_CYCLES consecutive cycles; tracks streak, multiplier and score.
module score_tracker #(
   parameter int NOTE_W      = 4,
   parameter int NOTE_OFFSET = 1,
   parameter int NOTE_MIN    = 1,
   parameter int NOTE_MAX    = 13,
   parameter int HOLD_CYCLES = 4,
   parameter int SCORE_W     = 17,
   parameter int STREAK_W    = 8,
   parameter int STREAK_STEP = 8,
   parameter int MULT_MAX    = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clear,
   input  logic [NOTE_W-1:0]   current_note,
   input  logic [NOTE_W-1:0]   correct_note,
   input  logic                note_strobe,
   output logic                hit,
   output logic                miss,
   output logic [SCORE_W-1:0]  score,
   output logic [STREAK_W-1:0] streak,
   output logic [3:0]          multiplier,
   output logic [NOTE_W-1:0]   note_played
);

   localparam int NOTE_RANGE = NOTE_MAX - NOTE_MIN + 1;

   typedef enum logic [1:0] {REST, WAIT, HOLD, SCORED} state_t;

   state_t              state_q, state_d;
   logic [NOTE_W-1:0]   target_q, target_d;
   logic [7:0]          hold_cnt_q, hold_cnt_d;
   logic                hit_q, hit_d;
   logic                miss_q, miss_d;
   logic [SCORE_W-1:0]  score_q, score_d;
   logic [STREAK_W-1:0] streak_q, streak_d;
   logic [3:0]          mult_q, mult_d;
   logic [NOTE_W-1:0]   note_q, note_d;

   logic [NOTE_W:0]     cur_ext;
   logic [NOTE_W:0]     norm_wide;
   logic [NOTE_W-1:0]   norm_note;
   logic                match;
   logic                do_score;
   logic [SCORE_W:0]    score_sum;
   logic [SCORE_W-1:0]  score_sat;
   logic [STREAK_W-1:0] streak_inc;
   logic [STREAK_W-1:0] streak_div;
   logic [3:0]          mult_next;

   // Low detector codes wrap to the top of the chart range instead of through zero.
   always_comb begin
      cur_ext   = {1'b0, current_note};
      norm_wide = '0;
      if (current_note == '0) begin
         norm_wide = '0;
      end else if (cur_ext < (NOTE_W+1)'(NOTE_MIN + NOTE_OFFSET)) begin
         norm_wide = cur_ext + (NOTE_W+1)'(NOTE_RANGE) - (NOTE_W+1)'(NOTE_OFFSET);
      end else begin
         norm_wide = cur_ext - (NOTE_W+1)'(NOTE_OFFSET);
      end
      norm_note = NOTE_W'(norm_wide);
      match     = (norm_note == target_q) && (target_q != '0);
   end

   // Multiplier follows the streak value that includes the hit being scored.
   always_comb begin
      score_sum  = {1'b0, score_q} + (SCORE_W+1)'(mult_q);
      score_sat  = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
      streak_inc = (streak_q == {STREAK_W{1'b1}}) ? streak_q : streak_q + 1'b1;
      streak_div = streak_inc / STREAK_W'(STREAK_STEP);
      if (streak_div >= STREAK_W'(MULT_MAX - 1)) begin
         mult_next = 4'(MULT_MAX);
      end else begin
         mult_next = 4'(streak_div) + 4'd1;
      end
   end

   always_comb begin
      state_d    = state_q;
      target_d   = target_q;
      hold_cnt_d = hold_cnt_q;
      hit_d      = 1'b0;
      miss_d     = 1'b0;
      score_d    = score_q;
      streak_d   = streak_q;
      mult_d     = mult_q;
      note_d     = norm_note;
      do_score   = 1'b0;

      if (clear) begin
         state_d    = REST;
         target_d   = '0;
         hold_cnt_d = '0;
         score_d    = '0;
         streak_d   = '0;
         mult_d     = 4'd1;
         note_d     = '0;
      end else if (note_strobe) begin
         target_d   = correct_note;
         hold_cnt_d = '0;
         state_d    = (correct_note == '0) ? REST : WAIT;
         if (state_q == WAIT || state_q == HOLD) begin
            miss_d   = 1'b1;
            streak_d = '0;
            mult_d   = 4'd1;
         end
      end else begin
         unique case (state_q)
            WAIT: begin
               if (match) begin
                  if (HOLD_CYCLES == 1) begin
                     do_score = 1'b1;
                  end else begin
                     state_d    = HOLD;
                     hold_cnt_d = 8'd1;
                  end
               end
            end
            HOLD: begin
               if (!match) begin
                  state_d    = WAIT;
                  hold_cnt_d = '0;
               end else if (hold_cnt_q == 8'(HOLD_CYCLES - 1)) begin
                  do_score = 1'b1;
               end else begin
                  hold_cnt_d = hold_cnt_q + 8'd1;
               end
            end
            default: begin
            end
         endcase

         if (do_score) begin
            state_d    = SCORED;
            hold_cnt_d = '0;
            hit_d      = 1'b1;
            score_d    = score_sat;
            streak_d   = streak_inc;
            mult_d     = mult_next;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= REST;
         target_q   <= '0;
         hold_cnt_q <= '0;
         hit_q      <= 1'b0;
         miss_q     <= 1'b0;
         score_q    <= '0;
         streak_q   <= '0;
         mult_q     <= 4'd1;
         note_q     <= '0;
      end else begin
         state_q    <= state_d;
         target_q   <= target_d;
         hold_cnt_q <= hold_cnt_d;
         hit_q      <= hit_d;
         miss_q     <= miss_d;
         score_q    <= score_d;
         streak_q   <= streak_d;
         mult_q     <= mult_d;
         note_q     <= note_d;
      end
   end

   assign hit         = hit_q;
   assign miss        = miss_q;
   assign score       = score_q;
   assign streak      = streak_q;
   assign multiplier  = mult_q;
   assign note_played = note_q;

endmodule

// File: tb/tb_score_tracker.sv
// Scoreboard bench for score_tracker: a window-level reference model predicts each
// cycle's outputs and every hit/miss event; a monitor compares at the falling edge.
module tb_score_tracker;

   localparam int HOLD      = 4;
   localparam int STEP      = 8;
   localparam int MMAX      = 4;
   localparam int SCORE_MAX = 131071;
   localparam int SMALL_MAX = 63;

   typedef struct {
      bit is_hit;
      int edge_no;
   } ev_t;

   typedef struct {
      int note;
      int score;
      int score_s;
      int streak;
      int mult;
      bit hit;
      bit miss;
   } cyc_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        clear;
   logic        note_strobe;
   logic [3:0]  current_note;
   logic [3:0]  correct_note;
   logic        hit, miss, hit_s, miss_s;
   logic [16:0] score;
   logic [5:0]  score_s;
   logic [7:0]  streak, streak_s;
   logic [3:0]  multiplier, mult_s, note_played, note_played_s;

   int errors = 0;
   int checks = 0;
   int edge_cnt = 0;

   ev_t  ev_q[$];
   cyc_t st_q[$];

   int  m_target, m_run, m_score, m_score_s, m_streak, m_mult;
   bit  m_scored;

   score_tracker dut (
      .clk(clk), .reset(reset), .clear(clear), .current_note(current_note),
      .correct_note(correct_note), .note_strobe(note_strobe), .hit(hit), .miss(miss),
      .score(score), .streak(streak), .multiplier(multiplier), .note_played(note_played)
   );

   // Narrow-score copy so saturation is reachable in a short run.
   score_tracker #(.SCORE_W(6)) dut_s (
      .clk(clk), .reset(reset), .clear(clear), .current_note(current_note),
      .correct_note(correct_note), .note_strobe(note_strobe), .hit(hit_s), .miss(miss_s),
      .score(score_s), .streak(streak_s), .multiplier(mult_s), .note_played(note_played_s)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int normRef(input int code);
      if (code == 0) return 0;
      if (code < 2) return (code - 1 + 13) % 16;
      return (code - 1) % 16;
   endfunction

   function automatic int codeFor(input int t);
      if (t == 0) return 0;
      if (t == 13) return ($urandom_range(0, 1) == 0) ? 1 : 14;
      return t + 1;
   endfunction

   task automatic modelReset();
      m_target  = 0;
      m_run     = 0;
      m_scored  = 1'b0;
      m_score   = 0;
      m_score_s = 0;
      m_streak  = 0;
      m_mult    = 1;
   endtask

   // Drive one cycle of inputs, predict the outcome of the coming edge, then take it.
   task automatic applyStimulus(input bit strb, input int corr, input int cur, input bit clr);
      int   n;
      bit   h, ms;
      ev_t  ev;
      cyc_t st;
      h  = 1'b0;
      ms = 1'b0;
      note_strobe  = strb;
      correct_note = 4'(corr);
      current_note = 4'(cur);
      clear        = clr;
      n = normRef(cur);
      if (clr) begin
         modelReset();
      end else if (strb) begin
         if (m_target != 0 && !m_scored) begin
            ms       = 1'b1;
            m_streak = 0;
            m_mult   = 1;
         end
         m_target = corr;
         m_scored = 1'b0;
         m_run    = 0;
      end else if (m_target != 0 && !m_scored) begin
         if (n == m_target) begin
            m_run++;
            if (m_run == HOLD) begin
               h         = 1'b1;
               m_scored  = 1'b1;
               m_score   = (m_score + m_mult > SCORE_MAX) ? SCORE_MAX : m_score + m_mult;
               m_score_s = (m_score_s + m_mult > SMALL_MAX) ? SMALL_MAX : m_score_s + m_mult;
               m_streak  = (m_streak == 255) ? 255 : m_streak + 1;
               m_mult    = (1 + m_streak / STEP > MMAX) ? MMAX : 1 + m_streak / STEP;
            end
         end else begin
            m_run = 0;
         end
      end
      if (h || ms) begin
         ev.is_hit  = h;
         ev.edge_no = edge_cnt + 1;
         ev_q.push_back(ev);
      end
      st.note    = clr ? 0 : n;
      st.score   = m_score;
      st.score_s = m_score_s;
      st.streak  = m_streak;
      st.mult    = m_mult;
      st.hit     = h;
      st.miss    = ms;
      st_q.push_back(st);
      @(posedge clk);
      #1;
   endtask

   // Asynchronous reset in the middle of a cycle; outputs must clear before any edge.
   task automatic doReset();
      @(negedge clk);
      #1 reset = 1'b0;
      #1;
      checkOutput("rst_hit", int'(hit), 0);
      checkOutput("rst_miss", int'(miss), 0);
      checkOutput("rst_score", int'(score), 0);
      checkOutput("rst_streak", int'(streak), 0);
      checkOutput("rst_mult", int'(multiplier), 1);
      checkOutput("rst_note", int'(note_played), 0);
      checkOutput("rst_score_s", int'(score_s), 0);
      modelReset();
      #1 reset = 1'b1;
   endtask

   task automatic playHit(input int t);
      applyStimulus(1'b1, t, 0, 1'b0);
      for (int i = 0; i < HOLD; i++) applyStimulus(1'b0, t, codeFor(t), 1'b0);
   endtask

   always @(negedge clk) begin
      ev_t  ev;
      cyc_t st;
      if (reset) begin
         checkOutput("hit_and_miss", int'(hit && miss), 0);
         if (hit || miss) begin
            if (ev_q.size() == 0) begin
               checkOutput("unexpected_event", int'({hit, miss}), 0);
            end else begin
               ev = ev_q.pop_front();
               checkOutput("event_kind_hit", int'(hit), int'(ev.is_hit));
               checkOutput("event_edge", edge_cnt, ev.edge_no);
            end
         end
         if (st_q.size() > 0) begin
            st = st_q.pop_front();
            checkOutput("note_played", int'(note_played), st.note);
            checkOutput("score", int'(score), st.score);
            checkOutput("streak", int'(streak), st.streak);
            checkOutput("multiplier", int'(multiplier), st.mult);
            checkOutput("hit", int'(hit), int'(st.hit));
            checkOutput("miss", int'(miss), int'(st.miss));
            checkOutput("small_score", int'(score_s), st.score_s);
            checkOutput("small_hit", int'(hit_s), int'(st.hit));
            checkOutput("small_miss", int'(miss_s), int'(st.miss));
            checkOutput("small_streak", int'(streak_s), st.streak);
            checkOutput("small_mult", int'(mult_s), st.mult);
            checkOutput("small_note", int'(note_played_s), st.note);
         end
      end
   end

   initial begin
      int t, len, code;
      reset        = 1'b1;
      clear        = 1'b0;
      note_strobe  = 1'b0;
      current_note = '0;
      correct_note = '0;
      modelReset();
      #2 reset = 1'b0;
      #2;
      checkOutput("init_hit", int'(hit), 0);
      checkOutput("init_miss", int'(miss), 0);
      checkOutput("init_score", int'(score), 0);
      checkOutput("init_streak", int'(streak), 0);
      checkOutput("init_mult", int'(multiplier), 1);
      checkOutput("init_note", int'(note_played), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1 reset = 1'b1;

      // First hit lands on the cycle after the fourth matching cycle.
      playHit(4);
      checkOutput("tp1_hit", int'(hit), 1);
      checkOutput("tp1_score", int'(score), 1);
      checkOutput("tp1_streak", int'(streak), 1);
      checkOutput("tp1_note", int'(note_played), 4);

      applyStimulus(1'b1, 13, 1, 1'b0);
      for (int i = 0; i < HOLD; i++) applyStimulus(1'b0, 13, 1, 1'b0);
      checkOutput("wrap_hit", int'(hit), 1);
      checkOutput("wrap_note", int'(note_played), 13);
      applyStimulus(1'b1, 13, 0, 1'b0);
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 13, 0, 1'b0);
      checkOutput("silence_no_hit", int'(hit), 0);

      applyStimulus(1'b1, 6, 7, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 6, 7, 1'b0);
      applyStimulus(1'b0, 6, 0, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 6, 7, 1'b0);
      checkOutput("break_hit", int'(hit), 1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 6, 7, 1'b0);
      applyStimulus(1'b1, 7, 0, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 7, 3, 1'b0);
      applyStimulus(1'b1, 7, 3, 1'b0);
      checkOutput("miss_pulse", int'(miss), 1);
      checkOutput("miss_streak", int'(streak), 0);
      checkOutput("miss_mult", int'(multiplier), 1);
      applyStimulus(1'b1, 0, 0, 1'b0);
      applyStimulus(1'b0, 0, 1, 1'b0);
      applyStimulus(1'b1, 5, 0, 1'b0);
      checkOutput("rest_no_miss", int'(miss), 0);

      applyStimulus(1'b0, 0, 0, 1'b1);
      for (int k = 1; k <= 32; k++) begin
         playHit(4);
         if (k == 8) checkOutput("mult_after_8", int'(multiplier), 2);
         if (k == 24) checkOutput("mult_after_24", int'(multiplier), 4);
      end
      checkOutput("score_after_32", int'(score), 80);
      checkOutput("small_score_sat", int'(score_s), 63);

      applyStimulus(1'b1, 4, 0, 1'b0);
      applyStimulus(1'b0, 4, 5, 1'b0);
      applyStimulus(1'b0, 4, 5, 1'b0);
      doReset();
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4, 5, 1'b0);

      applyStimulus(1'b1, 4, 0, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4, 5, 1'b0);
      applyStimulus(1'b1, 4, 5, 1'b1);
      checkOutput("clear_no_hit", int'(hit), 0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4, 5, 1'b0);

      for (int w = 0; w < 250; w++) begin
         t   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 13));
         len = $urandom_range(1, 8);
         applyStimulus(1'b1, t, $urandom_range(0, 15), 1'b0);
         for (int i = 0; i < len; i++) begin
            code = ($urandom_range(0, 9) < 7) ? codeFor(t) : int'($urandom_range(0, 15));
            applyStimulus(1'b0, t, code, ($urandom_range(0, 99) < 2));
         end
         if ($urandom_range(0, 99) < 2) doReset();
      end

      applyStimulus(1'b0, 0, 0, 1'b0);
      applyStimulus(1'b0, 0, 0, 1'b0);
      @(negedge clk);
      #1;
      checkOutput("pending_events", ev_q.size(), 0);
      checkOutput("pending_cycles", st_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/score_tracker.md
Name: score_tracker

Overview:
- Parametrised successor of the single-note scorer in the recorder game pipeline.
- Sits between the pitch detector, which supplies the played note, and the chart sequencer, which supplies the expected note plus a strobe each time a new chart note opens.
- Normalises the detector's offset note code and requires the correct note to be held for a programmable number of cycles.
- Scores each chart note at most once, reports hit/miss pulses, and tracks streak, multiplier and a saturating score for the display.

Parameters:
- NOTE_W, 4, width of note codes; code 0 = silence/rest.
- NOTE_OFFSET, 1, detector code minus this = chart code.
- NOTE_MIN, 1, lowest valid chart code.
- NOTE_MAX, 13, highest valid chart code; wrap target for normalisation.
- HOLD_CYCLES, 4, consecutive matching cycles needed to register a hit; legal range 1..255.
- SCORE_W, 17, score width.
- STREAK_W, 8, streak counter width.
- STREAK_STEP, 8, hits per multiplier step.
- MULT_MAX, 4, multiplier cap; 1..15.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous, active-low reset.
- clear, in, 1, synchronous song restart; same effect as reset.
- current_note, in, NOTE_W, raw detector note code.
- correct_note, in, NOTE_W, chart note code, valid when note_strobe = 1.
- note_strobe, in, 1, one-cycle pulse: new chart note window opens.
- hit, out, 1, one-cycle pulse: current chart note scored.
- miss, out, 1, one-cycle pulse: a window closed unscored.
- score, out, SCORE_W, accumulated score.
- streak, out, STREAK_W, consecutive hits; saturates at all-ones.
- multiplier, out, 4, current multiplier, 1..MULT_MAX.
- note_played, out, NOTE_W, registered normalised played note.

Behaviour:
- Reset (reset = 0, any time, asynchronous):
  - hit = miss = 0, score = 0, streak = 0, multiplier = 1, note_played = 0.
  - State = REST, target = 0, hold_cnt = 0.
- clear = 1 gives identical values on the next edge and has priority over every other input.
- Normalisation (combinational, registered into note_played each cycle, 1-cycle latency):
  - current_note = 0 gives n = 0.
  - current_note < NOTE_MIN + NOTE_OFFSET gives n = current_note - NOTE_OFFSET + (NOTE_MAX - NOTE_MIN + 1).
  - Otherwise n = current_note - NOTE_OFFSET.
  - With defaults: code 1 maps to 13 and code 5 maps to 4.
  - Computed at NOTE_W+1 bits, no wrap through zero.
- match = (n == target) and (target != 0).
- States: REST, WAIT, HOLD, SCORED.
- note_strobe (highest priority after clear/reset):
  - target <= correct_note, hold_cnt <= 0.
  - Next state = REST if correct_note == 0, else WAIT.
  - The old window closes. If the old state was WAIT or HOLD, miss = 1 next cycle, streak <= 0, multiplier <= 1.
  - A match in the strobe cycle counts for nothing; the old note is not scored.
- WAIT: match moves to HOLD with hold_cnt = 1. If HOLD_CYCLES == 1, go straight to SCORED and score (see below).
- HOLD:
  - Match with hold_cnt < HOLD_CYCLES - 1: hold_cnt++.
  - Match with hold_cnt == HOLD_CYCLES - 1: move to SCORED and score.
  - No match: back to WAIT, hold_cnt = 0.
- SCORED and REST: ignore current_note until the next note_strobe.
- Scoring edge (single clock edge):
  - hit <= 1 for exactly one cycle.
  - score <= min(score + multiplier, all-ones); saturating, never wraps.
  - streak <= streak + 1, saturating.
  - multiplier <= min(1 + (streak+1)/STREAK_STEP, MULT_MAX), computed from the updated streak.
- Hit latency: hit asserts the cycle after the HOLD_CYCLES-th consecutive matching cycle.
- hit and miss are never high in the same cycle.
- A rest note (target 0) never produces hit or miss.
- Reset or clear mid-window discards the window silently; no miss pulse.

Test Plan:
- Reset, then strobe correct = 4; hold current = 5 for 4 cycles → hit in cycle 5 after the strobe, score = 1, streak = 1, note_played = 4.
- Strobe correct = 13, current = 1 (wrap) held 4 cycles → hit, note_played = 13; current = 0 → never a hit.
- Match 3 cycles, break 1 cycle, match 4 cycles → only one hit, on the 4th cycle of the second run. Keep matching → no second hit; next strobe gives no miss.
- Strobe note 7, no match, strobe again → miss pulse 1 cycle after the second strobe, streak = 0, multiplier = 1. Strobe with correct = 0 then strobe again → no miss.
- 8 consecutive hits → multiplier 2 after the 8th. Next hit adds 2. Continue to multiplier = 4 cap after 24 hits. Force score near 2^17 - 1 → saturates at 131071.
- Assert reset low mid-HOLD → all outputs 0 / multiplier 1 immediately, no miss. clear coinciding with note_strobe and match → clear wins, no hit.
